lut_eval_seq: RTL and testbench

LUT_EVAL_SEQ -- requirements
Module: lut_eval_seq

---
 rtl/lut_eval_seq.sv | 170 +++++++++++++++++
 tb/tb_lut_eval_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_eval_seq.sv
//------------------------------------------------------------------------------
// Module      : lut_eval_seq
// Description : Registered truth-table evaluator with a ready/valid input and
//               output stage and a serially reloadable, double-buffered table.
//               Define LUT_EVAL_TOGGLE_CNT_EN to add the toggle_cnt output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lut_eval_seq #(
    parameter int                 N_IN       = 3,
    parameter logic [2**N_IN-1:0] INIT_TABLE = 8'h78
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_done,
    output logic            busy
`ifdef LUT_EVAL_TOGGLE_CNT_EN
    ,
    output logic [15:0]     toggle_cnt
`endif
);

    localparam int              c_DEPTH    = 2**N_IN;
    localparam logic [N_IN-1:0] c_LAST_IDX = N_IN'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_DEPTH-1:0]   r_table_a;
    logic [c_DEPTH-1:0]   r_table_s;
    logic [c_DEPTH-1:0]   w_shadow_next;
    logic [N_IN-1:0]      r_idx;
    logic                 r_cfg_done;
    logic                 r_out;
    logic                 r_out_valid;
    logic                 w_accept;
    logic                 w_result;
    logic                 w_cfg_write;
    logic                 w_commit;
    logic                 w_idx_clear;

    //--------------------------------------------------------------------------
    // Load-control FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cfg_write  = 1'b0;
        w_commit     = 1'b0;
        w_idx_clear  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (cfg_start) begin
                    w_state_next = ST_LOAD;
                    w_idx_clear  = 1'b1;
                end
            end
            ST_LOAD: begin
                // A restart wins over a data bit presented in the same cycle.
                if (cfg_start) begin
                    w_idx_clear = 1'b1;
                end else if (cfg_valid) begin
                    w_cfg_write = 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        w_commit     = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Shadow contents including this cycle's bit, so the commit sees the final bit.
    always_comb begin
        w_shadow_next = r_table_s;
        if (w_cfg_write) begin
            w_shadow_next[r_idx] = cfg_bit;
        end
    end

    //--------------------------------------------------------------------------
    // Table storage and load index
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_table_a  <= INIT_TABLE;
            r_table_s  <= INIT_TABLE;
            r_idx      <= '0;
            r_cfg_done <= 1'b0;
        end else begin
            r_cfg_done <= w_commit;
            r_table_s  <= w_shadow_next;
            if (w_idx_clear) begin
                r_idx <= '0;
            end else if (w_cfg_write) begin
                r_idx <= r_idx + N_IN'(1);
            end
            if (w_commit) begin
                r_table_a <= w_shadow_next;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Evaluation pipeline: one output register, full throughput
    //--------------------------------------------------------------------------
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    // Reads the active table as it stands before any same-edge commit.
    assign w_result = r_table_a[in_data];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out       <= w_result;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef LUT_EVAL_TOGGLE_CNT_EN
    logic [15:0] r_toggle_cnt;

    // r_out always holds the previous accepted result (0 straight after reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle_cnt <= 16'd0;
        end else if (w_accept && (w_result != r_out) && (r_toggle_cnt != 16'hFFFF)) begin
            r_toggle_cnt <= r_toggle_cnt + 16'd1;
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`endif

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign cfg_done  = r_cfg_done;
    assign busy      = (r_state == ST_LOAD);

endmodule

`default_nettype wire

// File: tb/tb_lut_eval_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_lut_eval_seq
// Description : Self-checking bench for lut_eval_seq against a table model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lut_eval_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       cfg_done;
    logic       busy;
`ifdef LUT_EVAL_TOGGLE_CNT_EN
    logic [15:0] toggle_cnt;
`endif

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] m_tab    = 8'h78;

    lut_eval_seq #(.N_IN(3), .INIT_TABLE(8'h78)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_done  (cfg_done),
        .busy      (busy)
`ifdef LUT_EVAL_TOGGLE_CNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        m_tab = 8'h78;
    endtask

    task automatic eval_one(input logic [2:0] d);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    // Starts a load and shifts nbits of val in, LSB first.
    task automatic cfg_load(input logic [7:0] val, input int nbits);
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1; cfg_bit = val[i];
            cycle();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out !== 1'b0) $display("FAIL reset_out: got %b want 0", out); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (cfg_done !== 1'b0) $display("FAIL reset_cfg_done: got %b want 0", cfg_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
`ifdef LUT_EVAL_TOGGLE_CNT_EN
        n_checks++; if (toggle_cnt !== 16'd0) $display("FAIL reset_toggle: got %0d want 0", toggle_cnt); else n_pass++;
`endif
    endtask

    task automatic test_default_table();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 3'(i);
            cycle();
            n_checks++;
            if (out !== m_tab[i] || out_valid !== 1'b1)
                $display("FAIL default_eval[%0d]: got out=%b v=%b want out=%b v=1", i, out, out_valid, m_tab[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        cycle();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 3'd1;
        cycle();
        n_checks++;
        if (out !== m_tab[1] || out_valid !== 1'b1)
            $display("FAIL bp_first: got out=%b v=%b want out=%b v=1", out, out_valid, m_tab[1]);
        else n_pass++;
        in_data = 3'd6;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); else n_pass++;
            cycle();
            n_checks++;
            if (out !== m_tab[1] || out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: got out=%b v=%b want out=%b v=1", i, out, out_valid, m_tab[1]);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
        cycle();
        n_checks++;
        if (out !== m_tab[6] || out_valid !== 1'b1)
            $display("FAIL bp_release_out: got out=%b v=%b want out=%b v=1", out, out_valid, m_tab[6]);
        else n_pass++;
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_reload();
        int done_cnt;
        done_cnt = 0;
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL reload_busy: got %b want 1", busy); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'((8'h96 >> i) & 1);
            cycle();
            done_cnt += int'(cfg_done);
        end
        cfg_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL reload_busy_end: got %b want 0", busy); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle();
            done_cnt += int'(cfg_done);
        end
        n_checks++; if (done_cnt != 1) $display("FAIL reload_done_pulses: got %0d want 1", done_cnt); else n_pass++;
        m_tab = 8'h96;
        eval_one(3'b011);
        n_checks++; if (out !== m_tab[3]) $display("FAIL reload_eval3: got %b want %b", out, m_tab[3]); else n_pass++;
        eval_one(3'b001);
        n_checks++; if (out !== m_tab[1]) $display("FAIL reload_eval1: got %b want %b", out, m_tab[1]); else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] seen;
        cfg_load(8'h00, 4);
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_mid: got %b want 1", busy); else n_pass++;
        // The active table must still serve lookups while a load is in progress.
        seen = '0;
        for (int i = 0; i < 8; i++) begin eval_one(3'(i)); seen[i] = out; end
        n_checks++; if (seen !== m_tab) $display("FAIL eval_during_load: got %h want %h", seen, m_tab); else n_pass++;
        cfg_load(8'hFF, 8);
        m_tab = 8'hFF;
        cycle();
        seen = '0;
        for (int i = 0; i < 8; i++) begin eval_one(3'(i)); seen[i] = out; end
        n_checks++; if (seen !== m_tab) $display("FAIL abort_restart_table: got %h want %h", seen, m_tab); else n_pass++;
        cfg_load(8'h00, 5);
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_in_load_busy: got %b want 0", busy); else n_pass++;
        seen = '0;
        for (int i = 0; i < 8; i++) begin eval_one(3'(i)); seen[i] = out; end
        n_checks++; if (seen !== m_tab) $display("FAIL rst_in_load_table: got %h want %h", seen, m_tab); else n_pass++;
    endtask

    task automatic test_commit_cycle();
        logic old_bit;
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin cfg_valid = 1'b1; cfg_bit = 1'b1; cycle(); end
        cfg_bit = 1'b1; in_valid = 1'b1; in_data = 3'b000; out_ready = 1'b1;
        cycle();
        cfg_valid = 1'b0; in_valid = 1'b0;
        old_bit = m_tab[0];
        m_tab = 8'hFF;
        n_checks++; if (out !== old_bit) $display("FAIL commit_cycle_old: got %b want %b", out, old_bit); else n_pass++;
        n_checks++; if (cfg_done !== 1'b1) $display("FAIL commit_cfg_done: got %b want 1", cfg_done); else n_pass++;
        eval_one(3'b000);
        n_checks++; if (out !== m_tab[0]) $display("FAIL commit_next_new: got %b want %b", out, m_tab[0]); else n_pass++;
        eval_one(3'b101);
        n_checks++; if (out !== m_tab[5]) $display("FAIL commit_next_5: got %b want %b", out, m_tab[5]); else n_pass++;
    endtask

    task automatic test_random();
        logic       exp_valid, exp_out, acc;
        logic [7:0] t;
        int         errs;
        t = 8'($urandom);
        cfg_load(t, 8);
        m_tab = t;
        cycle();
        exp_valid = out_valid;
        exp_out   = out;
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_bit   = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (in_ready !== (!exp_valid || out_ready)) begin
                errs++;
                if (errs < 10) $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, !exp_valid || out_ready);
            end else n_pass++;
            acc = in_valid && (!exp_valid || out_ready);
            if (acc) begin exp_out = m_tab[in_data]; exp_valid = 1'b1; end
            else if (out_ready) exp_valid = 1'b0;
            cycle();
            n_checks++;
            if (out_valid !== exp_valid || (exp_valid && out !== exp_out) || busy !== 1'b0) begin
                errs++;
                if (errs < 10) $display("FAIL rand_out[%0d]: got out=%b v=%b busy=%b want out=%b v=%b busy=0",
                                        c, out, out_valid, busy, exp_out, exp_valid);
            end else n_pass++;
        end
        in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
        cycle();
    endtask

`ifdef LUT_EVAL_TOGGLE_CNT_EN
    task automatic test_toggle();
        logic [2:0] seq [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
        logic       prev;
        int         cnt;
        do_reset();
        cfg_load(8'h96, 8);
        m_tab = 8'h96;
        cycle();
        prev = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            eval_one(seq[i]);
            if (m_tab[seq[i]] != prev && cnt < 65535) cnt++;
            prev = m_tab[seq[i]];
        end
        n_checks++; if (toggle_cnt !== 16'(cnt)) $display("FAIL toggle_cnt: got %0d want %0d", toggle_cnt, cnt); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_default_table();
        test_backpressure();
        test_reload();
        test_abort();
        test_commit_cycle();
        test_random();
`ifdef LUT_EVAL_TOGGLE_CNT_EN
        test_toggle();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
